// File: rtl/t_flip_flop_pkg.sv
// Shared defaults and helpers for the toggle flip-flop bank and its event counter.
package t_flip_flop_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;
  localparam logic [63:0] DEFAULT_RESET_VAL = '0;

  // Increment a value of the given bit width, holding at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : (value + 32'd1);
  endfunction

endpackage

// File: rtl/t_flip_flop_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; stops at all-ones.
module t_flip_flop_sat_counter
  import t_flip_flop_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= CNT_W'(sat_inc(32'(count), CNT_W));
    end
  end

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH toggle flip-flops with complement output, a one-cycle toggled flag
// and a saturating count of edges on which any bit toggled.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL),
  parameter int               CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             toggled,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic any_toggle;

  assign any_toggle = |t;
  assign qn         = ~q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RESET_VAL;
      toggled <= 1'b0;
    end else begin
      q       <= q ^ t;
      toggled <= any_toggle;
    end
  end

  // The counter advances on exactly the edges that set toggled.
  t_flip_flop_sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (any_toggle),
    .count(toggle_cnt)
  );

endmodule

// File: tb/tb_t_flip_flop.sv
// Scoreboard bench for t_flip_flop: a 1-bit/8-bit-counter instance and a 4-bit/2-bit-counter instance.
module tb_t_flip_flop;

  typedef struct {
    int q;
    int tg;
    int cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [0:0] t_a;
  logic [0:0] q_a, qn_a;
  logic       tg_a;
  logic [7:0] cnt_a;
  logic [3:0] t_b;
  logic [3:0] q_b, qn_b;
  logic       tg_b;
  logic [1:0] cnt_b;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers following the behavioural rules.
  int m_qa = 0, m_ca = 0, m_tga = 0;
  int m_qb = 0, m_cb = 0, m_tgb = 0;
  bit stim_done = 0;

  t_flip_flop dut_a (
    .clk       (clk),
    .rst       (rst),
    .t         (t_a),
    .q         (q_a),
    .qn        (qn_a),
    .toggled   (tg_a),
    .toggle_cnt(cnt_a)
  );

  t_flip_flop #(
    .WIDTH    (4),
    .RESET_VAL(4'b0000),
    .CNT_W    (2)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .t         (t_b),
    .q         (q_b),
    .qn        (qn_b),
    .toggled   (tg_b),
    .toggle_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_qa = 0; m_ca = 0; m_tga = 0;
    m_qb = 0; m_cb = 0; m_tgb = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input logic [0:0] ta, input logic [3:0] tb, input logic rst_val);
    exp_t e;
    @(negedge clk);
    rst = rst_val;
    t_a = ta;
    t_b = tb;
    if (!rst_val) begin
      modelReset();
    end else begin
      m_tga = (int'(ta) != 0) ? 1 : 0;
      if (m_tga == 1) begin
        m_qa = m_qa ^ int'(ta);
        m_ca = (m_ca < 255) ? m_ca + 1 : 255;
      end
      m_tgb = (int'(tb) != 0) ? 1 : 0;
      if (m_tgb == 1) begin
        m_qb = m_qb ^ int'(tb);
        m_cb = (m_cb < 3) ? m_cb + 1 : 3;
      end
    end
    e.q = m_qa; e.tg = m_tga; e.cnt = m_ca;
    exp_a.push_back(e);
    e.q = m_qb; e.tg = m_tgb; e.cnt = m_cb;
    exp_b.push_back(e);
  endtask

  // Monitor: every rising edge the DUTs present a new state; compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        checkOutput("a_q", int'(q_a), e.q);
        checkOutput("a_qn", int'(qn_a), e.q ^ 1);
        checkOutput("a_toggled", int'(tg_a), e.tg);
        checkOutput("a_cnt", int'(cnt_a), e.cnt);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        checkOutput("b_q", int'(q_b), e.q);
        checkOutput("b_qn", int'(qn_b), e.q ^ 15);
        checkOutput("b_toggled", int'(tg_b), e.tg);
        checkOutput("b_cnt", int'(cnt_b), e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b0;
    t_a = '0;
    t_b = '0;

    // Reset hold with random t on a running clock.
    for (int i = 0; i < 4; i++) applyStimulus(1'($urandom), 4'($urandom), 1'b0);

    // Continuous toggle on a, divide-by-2; b gets random traffic.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'($urandom), 1'b1);

    // Set a to 1, then hold for five edges.
    applyStimulus(1'b1, 4'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'($urandom), 1'b1);

    // Back to 0, then alternate t = 0,1,0,1.
    applyStimulus(1'b1, 4'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'(i % 2), 4'($urandom), 1'b1);

    // Leave a at 1 with a non-zero count, then drop reset between edges.
    applyStimulus(1'b1, 4'b0110, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_a_q", int'(q_a), 0);
    checkOutput("async_a_qn", int'(qn_a), 1);
    checkOutput("async_a_cnt", int'(cnt_a), 0);
    checkOutput("async_a_toggled", int'(tg_a), 0);
    checkOutput("async_b_q", int'(q_b), 0);
    checkOutput("async_b_cnt", int'(cnt_b), 0);

    // Release with t=1 on a; b runs 1010 for five edges to exercise saturation.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b1010, 1'b1);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom), 4'($urandom), ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
    end

    applyStimulus(1'b0, 4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("drain_a", exp_a.size(), 0);
    checkOutput("drain_b", exp_b.size(), 0);
    stim_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #20000;
    if (!stim_done) begin
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule

// File: doc/t_flip_flop.md
Name: t_flip_flop

Overview:
- Parameterised bank of toggle (T) flip-flops sharing one clock and one asynchronous active-low reset.
- Each bit of q inverts on a rising clock edge when its t bit is 1, and holds when its t bit is 0.
- Provides the complement output, a one-cycle "toggled" flag and a saturating toggle-event counter for status/debug use.
- Used as a divide-by-2 / parity / event-toggle primitive in control logic.

Parameters:
- WIDTH, 1, number of independent T flip-flops (bits of t/q); legal range 1..64.
- RESET_VAL, 0 (WIDTH bits), value loaded into q while rst is low.
- CNT_W, 8, width of toggle_cnt; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- t  input  WIDTH  per-bit toggle request, sampled on rising clk.
- q  output  WIDTH  registered flip-flop state.
- qn  output  WIDTH  combinational complement of q (~q).
- toggled  output  1  registered; 1 for the cycle after any bit of q changed.
- toggle_cnt  output  CNT_W  count of clock edges on which at least one bit toggled; saturating.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst = 0):
  - Applies immediately, independent of clk: q = RESET_VAL, qn = ~RESET_VAL, toggled = 0, toggle_cnt = 0.
  - Outputs hold these values for as long as rst stays low. Clock edges and t are ignored.
- Reset release: the first rising clk edge with rst = 1 performs normal operation. There is no extra synchronisation latency inside the block; the parent guarantees release timing.
- Normal operation, on each rising clk edge with rst = 1:
  - q <= q XOR t (per bit, latency 1 edge).
  - t bit = 0 → that bit holds.
  - t bit = 1 → that bit inverts.
  - Holding t = 1 continuously makes q divide clk by 2.
- qn is always the exact bitwise inverse of q, with no extra register.
- toggled:
  - Goes to 1 on the rising clk edge when t is non-zero (i.e. q changes on that edge).
  - Goes to 0 on an edge when t is all zeros.
- toggle_cnt:
  - Increments by 1 on every edge where toggled is set to 1.
  - Saturates at all-ones (2^CNT_W − 1) and does not wrap.
  - Cleared only by reset.
- Reset asserted mid-operation, including coincident with a rising clk edge: reset wins, so q = RESET_VAL and the counter clears that instant.
- t changing exactly at a falling edge has no effect; only the rising-edge value matters.
- No X propagation from q: q is always defined after reset. t containing X is a caller error, and the bench treats it as illegal stimulus.

Decomposition:
- Shared package t_flip_flop_pkg:
  - default constants for WIDTH (1), CNT_W (8) and RESET_VAL (0);
  - a function sat_inc(value, width) for the saturating increment.
- One natural sub-module: t_flip_flop_sat_counter (CNT_W-bit saturating event counter with async active-low clear). It is reusable elsewhere.
- The toggle register array, qn and toggled flag stay in the top module.

Test Plan:
1. Reset hold: rst = 0, t toggling, clk running for 40 time units → q = 0, qn = 1, toggled = 0, toggle_cnt = 0 throughout, with no change on any clk edge.
2. Basic toggle: WIDTH = 1, release rst, t = 1 held for 4 rising edges → q sequence 1, 0, 1, 0; toggled = 1 each cycle; toggle_cnt = 4.
3. Hold: q = 1, t = 0 for 5 rising edges → q stays 1, qn stays 0, toggled = 0, toggle_cnt unchanged.
4. Alternating t: t flips every full clock period (t = 0, 1, 0, 1 at successive rising edges) starting from q = 0 → q = 0, 1, 1, 0; toggle_cnt += 2.
5. Async reset mid-run: drive q = 1 and toggle_cnt = 7, then drop rst between clock edges → q = 0 and toggle_cnt = 0 within the same time step, before the next clk edge. Releasing rst with t = 1 gives q = 1 on the next rising edge.
6. Saturation and width: CNT_W = 2, WIDTH = 4, t = 4'b1010 for 5 edges from reset → q alternates 4'b1010 / 4'b0000, and toggle_cnt stops at 3.
